pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// The counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] ID_Rs1;
  logic [REG_AW-1:0] ID_Rs2;
  logic              ID_UseRs1;
  logic              ID_UseRs2;
  logic [REG_AW-1:0] EX_Rd;
  logic              EX_MemRead;
  logic              EX_BranchTaken;
  logic              MEM_Busy;
  logic              NoOp;
  logic              PCWrite;
  logic              Stall;
  logic              Freeze;
  logic              Flush;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  LoadStallCnt;
  logic [CNT_W-1:0]  MemStallCnt;
  logic [CNT_W-1:0]  FlushCnt;
`endif

  modport master (
    output ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_Rd, EX_MemRead, EX_BranchTaken, MEM_Busy,
    input  NoOp, PCWrite, Stall, Freeze, Flush
`ifdef HAZARD_PERF_CNT_EN
    , LoadStallCnt, MemStallCnt, FlushCnt
`endif
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_UseRs1, ID_UseRs2, EX_Rd, EX_MemRead, EX_BranchTaken, MEM_Busy,
    output NoOp, PCWrite, Stall, Freeze, Flush
`ifdef HAZARD_PERF_CNT_EN
    , LoadStallCnt, MemStallCnt, FlushCnt
`endif
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / memory-busy hazard controller for an in-order pipeline.
// Optional saturating performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic {IDLE, LOAD_STALL} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] ex_rd, id_rs1, id_rs2;
  logic            hit;
  logic            noop, pc_write, stall, freeze, flush;

  assign ex_rd  = hz.EX_Rd;
  assign id_rs1 = hz.ID_Rs1;
  assign id_rs2 = hz.ID_Rs2;

  // x0 is hardwired zero, so it can never carry a load-use dependency
  assign hit = hz.EX_MemRead && (ex_rd != '0) &&
               ((hz.ID_UseRs1 && (id_rs1 == ex_rd)) ||
                (hz.ID_UseRs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    noop     = 1'b0;
    pc_write = 1'b1;
    stall    = 1'b0;
    freeze   = 1'b0;
    flush    = 1'b0;
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hz.MEM_Busy) begin
      freeze   = 1'b1;
      stall    = 1'b1;
      pc_write = 1'b0;
    end else if (state_q == LOAD_STALL) begin
      noop     = 1'b1;
      stall    = 1'b1;
      pc_write = 1'b0;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end else if (hz.EX_BranchTaken) begin
      flush = 1'b1;
    end else if (hit) begin
      noop     = 1'b1;
      stall    = 1'b1;
      pc_write = 1'b0;
      // the detecting cycle is the first bubble; the rest are counted out in LOAD_STALL
      if (LOAD_LAT > 1) begin
        state_d = LOAD_STALL;
        cnt_d   = CW'(LOAD_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.NoOp    = noop;
  assign hz.PCWrite = pc_write;
  assign hz.Stall   = stall;
  assign hz.Freeze  = freeze;
  assign hz.Flush   = flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_stall_cnt_q, mem_stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_stall_cnt_q <= '0;
      mem_stall_cnt_q  <= '0;
      flush_cnt_q      <= '0;
    end else begin
      if (noop && !(&load_stall_cnt_q))  load_stall_cnt_q <= load_stall_cnt_q + CNT_W'(1);
      if (freeze && !(&mem_stall_cnt_q)) mem_stall_cnt_q  <= mem_stall_cnt_q + CNT_W'(1);
      if (flush && !(&flush_cnt_q))      flush_cnt_q      <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.LoadStallCnt = load_stall_cnt_q;
  assign hz.MemStallCnt  = mem_stall_cnt_q;
  assign hz.FlushCnt     = flush_cnt_q;
`endif
endmodule
